ifu_fetch: RTL and testbench

- Instruction fetch unit that owns the PC and issues one fetch at a time to the instruction cache through its CPU-side valid/ready read port.
- Buffers the returned instruction and presents it with its PC to the decode stage (IDU) over a valid/ready handshake.
- Accepts redirects (branch, jump, trap) from downstream.
- Responses that belong to a request issued before a redirect are discarded.

---
 rtl/ifu_pkg.sv | 14 +
 rtl/ifu_fetch_if.sv | 34 +++
 rtl/ifu_fetch.sv | 139 +++++++++++++
 tb/tb_ifu_fetch.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// rtl/ifu_pkg.sv - shared types and constants for the instruction fetch unit
package ifu_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } ifu_state_t;

    localparam logic [31:0] IFU_RESET_PC = 32'h3000_0000;
    localparam logic [31:0] IFU_PC_STEP  = 32'd4;

endpackage

// File: rtl/ifu_fetch_if.sv
// rtl/ifu_fetch_if.sv - redirect, icache read port and decode handshake bundle
interface ifu_fetch_if #(
    parameter int XLEN = 32
);
    logic            redirect_valid_i;
    logic [XLEN-1:0] redirect_pc_i;
    logic            icache_arvalid_o;
    logic            icache_arready_i;
    logic [XLEN-1:0] icache_araddr_o;
    logic            icache_rvalid_i;
    logic            icache_rready_o;
    logic [XLEN-1:0] icache_rdata_i;
    logic            idu_valid_o;
    logic            idu_ready_i;
    logic [XLEN-1:0] idu_inst_o;
    logic [XLEN-1:0] idu_pc_o;
    logic [31:0]     fetch_cnt_o;

    modport master (
        input  redirect_valid_i, redirect_pc_i,
        input  icache_arready_i, icache_rvalid_i, icache_rdata_i,
        input  idu_ready_i,
        output icache_arvalid_o, icache_araddr_o, icache_rready_o,
        output idu_valid_o, idu_inst_o, idu_pc_o, fetch_cnt_o
    );

    modport slave (
        output redirect_valid_i, redirect_pc_i,
        output icache_arready_i, icache_rvalid_i, icache_rdata_i,
        output idu_ready_i,
        input  icache_arvalid_o, icache_araddr_o, icache_rready_o,
        input  idu_valid_o, idu_inst_o, idu_pc_o, fetch_cnt_o
    );
endinterface

// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - single-outstanding instruction fetch FSM with redirect and stale-response drop
module ifu_fetch
    import ifu_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = IFU_RESET_PC
) (
    input  logic         clk,
    input  logic         rst_n,
    ifu_fetch_if.master  bus
);

    ifu_state_t      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] araddr_q, araddr_d;
    logic            arvalid_q, arvalid_d;
    logic            rready_q, rready_d;
    logic            discard_q, discard_d;
    logic            idu_valid_q, idu_valid_d;
    logic [XLEN-1:0] idu_inst_q, idu_inst_d;
    logic [XLEN-1:0] idu_pc_q, idu_pc_d;
    logic [31:0]     cnt_q, cnt_d;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] pc_next;

    assign target  = {bus.redirect_pc_i[XLEN-1:2], 2'b00};
    assign pc_next = pc_q + XLEN'(IFU_PC_STEP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= BOOT;
            pc_q        <= RESET_PC;
            araddr_q    <= RESET_PC;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            discard_q   <= 1'b0;
            idu_valid_q <= 1'b0;
            idu_inst_q  <= '0;
            idu_pc_q    <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            araddr_q    <= araddr_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            discard_q   <= discard_d;
            idu_valid_q <= idu_valid_d;
            idu_inst_q  <= idu_inst_d;
            idu_pc_q    <= idu_pc_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        araddr_d    = araddr_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        discard_d   = discard_q;
        idu_valid_d = idu_valid_q;
        idu_inst_d  = idu_inst_q;
        idu_pc_d    = idu_pc_q;
        cnt_d       = cnt_q;
        case (state_q)
            BOOT: begin
                state_d   = REQ;
                arvalid_d = 1'b1;
                pc_d      = bus.redirect_valid_i ? target : pc_q;
                araddr_d  = bus.redirect_valid_i ? target : pc_q;
            end
            REQ: begin
                // An accepted-but-redirected request still completes; its data is dropped later.
                if (bus.redirect_valid_i) begin
                    pc_d      = target;
                    discard_d = 1'b1;
                end
                if (bus.icache_arready_i) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (bus.icache_rvalid_i && rready_q) begin
                    rready_d = 1'b0;
                    if (bus.redirect_valid_i) begin
                        pc_d      = target;
                        araddr_d  = target;
                        discard_d = 1'b0;
                        arvalid_d = 1'b1;
                        state_d   = REQ;
                    end else if (discard_q) begin
                        araddr_d  = pc_q;
                        discard_d = 1'b0;
                        arvalid_d = 1'b1;
                        state_d   = REQ;
                    end else begin
                        idu_inst_d  = bus.icache_rdata_i;
                        idu_pc_d    = araddr_q;
                        idu_valid_d = 1'b1;
                        state_d     = HOLD;
                    end
                end else if (bus.redirect_valid_i) begin
                    pc_d      = target;
                    discard_d = 1'b1;
                end
            end
            HOLD: begin
                // A redirect here kills the buffered instruction even if decode is ready.
                if (bus.redirect_valid_i) begin
                    idu_valid_d = 1'b0;
                    pc_d        = target;
                    araddr_d    = target;
                    arvalid_d   = 1'b1;
                    state_d     = REQ;
                end else if (bus.idu_ready_i) begin
                    idu_valid_d = 1'b0;
                    pc_d        = pc_next;
                    araddr_d    = pc_next;
                    arvalid_d   = 1'b1;
                    cnt_d       = cnt_q + 32'd1;
                    state_d     = REQ;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    assign bus.icache_arvalid_o = arvalid_q;
    assign bus.icache_araddr_o  = araddr_q;
    assign bus.icache_rready_o  = rready_q;
    assign bus.idu_valid_o      = idu_valid_q;
    assign bus.idu_inst_o       = idu_inst_q;
    assign bus.idu_pc_o         = idu_pc_q;
    assign bus.fetch_cnt_o      = cnt_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// tb/tb_ifu_fetch.sv - randomized cache/decode environment with program-order scoreboard for ifu_fetch
module tb_ifu_fetch;
    import ifu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ifu_fetch_if #(.XLEN(32)) io ();
    ifu_fetch #(.XLEN(32), .RESET_PC(32'h3000_0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (io)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];
    int exp_cnt = 0;
    int delivered = 0;
    logic saw_wrap = 1'b0;

    int p_arready = 100;
    int p_ready = 100;
    int p_redirect = 0;
    logic force_redir = 1'b0;
    logic [31:0] force_tgt = '0;

    logic pend = 1'b0;
    int dly = 0;
    logic [31:0] pend_addr = '0;
    logic hs_ar = 1'b0;
    logic hs_r = 1'b0;
    logic [31:0] hs_addr = '0;

    // Memory image: each word is a hash of its address so stale data is distinguishable.
    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a == 32'h3000_0000) ? 32'h0000_0013 : ((a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic redirect_to(input logic [31:0] t);
        io.redirect_valid_i = 1'b1;
        io.redirect_pc_i    = t;
        exp_q.delete();
        exp_q.push_back({t[31:2], 2'b00});
    endtask

    // Cache and decode driver: inputs change on the falling edge only.
    initial begin
        io.redirect_valid_i = 1'b0;
        io.redirect_pc_i    = '0;
        io.icache_arready_i = 1'b0;
        io.icache_rvalid_i  = 1'b0;
        io.icache_rdata_i   = '0;
        io.idu_ready_i      = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                io.redirect_valid_i = 1'b0;
                io.icache_arready_i = 1'b0;
                io.icache_rvalid_i  = 1'b0;
                io.idu_ready_i      = 1'b0;
                pend = 1'b0;
                hs_ar = 1'b0;
                hs_r = 1'b0;
            end else begin
                if (hs_r) begin
                    io.icache_rvalid_i = 1'b0;
                    pend = 1'b0;
                end
                if (hs_ar) begin
                    pend = 1'b1;
                    dly = int'($urandom_range(0, 4));
                    pend_addr = hs_addr;
                end
                if (pend && !io.icache_rvalid_i) begin
                    if (dly == 0) begin
                        io.icache_rvalid_i = 1'b1;
                        io.icache_rdata_i  = mem(pend_addr);
                    end else begin
                        dly--;
                    end
                end
                io.icache_arready_i = int'($urandom_range(0, 99)) < p_arready;
                io.idu_ready_i      = int'($urandom_range(0, 99)) < p_ready;
                io.redirect_valid_i = 1'b0;
                if (force_redir) begin
                    redirect_to(force_tgt);
                    force_redir = 1'b0;
                end else if (int'($urandom_range(0, 99)) < p_redirect) begin
                    redirect_to($urandom);
                end
                hs_ar   = io.icache_arvalid_o && io.icache_arready_i;
                hs_addr = io.icache_araddr_o;
                hs_r    = io.icache_rvalid_i && io.icache_rready_o;
            end
        end
    end

    // Monitor: checks protocol rules and pops the expected program-order stream on each decode handshake.
    initial begin
        int outstanding;
        int idle;
        logic prev_ar_stall, prev_hold_stall;
        logic [31:0] prev_araddr, prev_inst, prev_pc, e;
        outstanding = 0;
        idle = 0;
        prev_ar_stall = 1'b0;
        prev_hold_stall = 1'b0;
        prev_araddr = '0;
        prev_inst = '0;
        prev_pc = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                outstanding = 0;
                idle = 0;
                prev_ar_stall = 1'b0;
                prev_hold_stall = 1'b0;
                continue;
            end
            chk("fetch_cnt", io.fetch_cnt_o, 32'(exp_cnt));
            if (prev_ar_stall) begin
                chk1("arvalid_held", io.icache_arvalid_o, 1'b1);
                chk("araddr_held", io.icache_araddr_o, prev_araddr);
            end
            if (prev_hold_stall) begin
                chk1("idu_valid_held", io.idu_valid_o, 1'b1);
                chk("idu_inst_held", io.idu_inst_o, prev_inst);
                chk("idu_pc_held", io.idu_pc_o, prev_pc);
            end
            if (io.idu_valid_o) chk1("no_fetch_in_hold", io.icache_arvalid_o, 1'b0);
            if (io.icache_arvalid_o) chk("single_outstanding", 32'(outstanding), 32'd0);
            if (io.idu_valid_o && io.idu_ready_i && !io.redirect_valid_i) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL idu_unexpected: got pc %h with no expected entry", io.idu_pc_o);
                end else begin
                    e = exp_q.pop_front();
                    chk("idu_pc", io.idu_pc_o, e);
                    chk("idu_inst", io.idu_inst_o, mem(e));
                    if (e == 32'h0000_0000) saw_wrap = 1'b1;
                    exp_q.push_back(e + 32'd4);
                end
                exp_cnt++;
                delivered++;
                idle = 0;
            end else begin
                idle++;
            end
            if (idle > 400) begin
                chk("idu_progress_idle", 32'(idle), 32'd0);
                idle = 0;
            end
            if (io.icache_arvalid_o && io.icache_arready_i) outstanding++;
            if (io.icache_rvalid_i && io.icache_rready_o) outstanding--;
            prev_ar_stall   = io.icache_arvalid_o && !io.icache_arready_i;
            prev_araddr     = io.icache_araddr_o;
            prev_hold_stall = io.idu_valid_o && !io.idu_ready_i && !io.redirect_valid_i;
            prev_inst       = io.idu_inst_o;
            prev_pc         = io.idu_pc_o;
        end
    end

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #3;
        chk1("rst_arvalid", io.icache_arvalid_o, 1'b0);
        chk1("rst_rready", io.icache_rready_o, 1'b0);
        chk1("rst_idu_valid", io.idu_valid_o, 1'b0);
        chk("rst_araddr", io.icache_araddr_o, 32'h3000_0000);
        chk("rst_fetch_cnt", io.fetch_cnt_o, 32'd0);
        chk("rst_idu_inst", io.idu_inst_o, 32'd0);
        chk("rst_idu_pc", io.idu_pc_o, 32'd0);
        exp_q.delete();
        exp_q.push_back(32'h3000_0000);
        exp_cnt = 0;
        rst_n = 1'b1;
        #4;
        chk1("boot_arvalid", io.icache_arvalid_o, 1'b1);
        chk("boot_araddr", io.icache_araddr_o, 32'h3000_0000);
        repeat (30) @(negedge clk);

        p_arready = 70; p_ready = 50; p_redirect = 6;
        repeat (300) @(negedge clk);

        p_arready = 0; p_redirect = 0;
        repeat (4) @(negedge clk);
        @(posedge clk);
        force_tgt = 32'h8000_0012;
        force_redir = 1'b1;
        repeat (10) @(negedge clk);
        p_arready = 80; p_ready = 60;
        repeat (40) @(negedge clk);

        @(posedge clk);
        force_tgt = 32'hFFFF_FFF6;
        force_redir = 1'b1;
        repeat (80) @(negedge clk);
        chk1("wrap_delivered", saw_wrap, 1'b1);

        p_redirect = 8; p_ready = 40;
        repeat (250) @(negedge clk);

        p_redirect = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #3;
            if (io.icache_rready_o) break;
        end
        chk1("wait_reached", io.icache_rready_o, 1'b1);
        rst_n = 1'b0;
        #1;
        chk1("arst_arvalid", io.icache_arvalid_o, 1'b0);
        chk1("arst_rready", io.icache_rready_o, 1'b0);
        chk1("arst_idu_valid", io.idu_valid_o, 1'b0);
        chk("arst_araddr", io.icache_araddr_o, 32'h3000_0000);
        chk("arst_fetch_cnt", io.fetch_cnt_o, 32'd0);
        chk("arst_idu_pc", io.idu_pc_o, 32'd0);
        exp_q.delete();
        exp_q.push_back(32'h3000_0000);
        exp_cnt = 0;
        repeat (2) @(negedge clk);
        #3;
        rst_n = 1'b1;
        #4;
        chk1("rearm_arvalid", io.icache_arvalid_o, 1'b1);
        chk("rearm_araddr", io.icache_araddr_o, 32'h3000_0000);
        repeat (60) @(negedge clk);
        chk1("delivered_any", delivered != 0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
